// File: rtl/pattern_pkg.sv
// Shared types and default widths for the pattern playback controller.
package pattern_pkg;

    localparam int unsigned DEFAULT_WORD_SIZE    = 8;
    localparam int unsigned DEFAULT_ADDRESS_SIZE = 4;
    localparam int unsigned DEFAULT_PERIOD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/pattern_controller_step_timer.sv
// Hold-time counter: counts up while not cleared, flags the last cycle of a period.
module step_timer
    import pattern_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = DEFAULT_PERIOD_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    expired
);

    logic [PERIOD_WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else begin
            count <= count + PERIOD_WIDTH'(1);
        end
    end

    assign expired = (count == (period - PERIOD_WIDTH'(1)));

endmodule

// File: rtl/pattern_controller.sv
// Playback controller: fetches words from pattern memory over an address range
// and holds each on the output for a programmable number of clocks.
module pattern_controller
    import pattern_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = DEFAULT_WORD_SIZE,
    parameter int unsigned ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
    parameter int unsigned PERIOD_WIDTH = DEFAULT_PERIOD_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop,
    input  logic [ADDRESS_SIZE-1:0] start_addr,
    input  logic [ADDRESS_SIZE-1:0] end_addr,
    input  logic [PERIOD_WIDTH-1:0] step_period,
    input  logic                    r_ready,
    input  logic [WORD_SIZE-1:0]    r_data,
    output logic                    r_en,
    output logic [ADDRESS_SIZE-1:0] r_addr,
    // "sequence" is a reserved word in SystemVerilog, hence the suffix
    output logic [WORD_SIZE-1:0]    sequence_word,
    output logic                    busy,
    output logic                    step,
    output logic                    done
);

    state_t state_q, state_d;

    logic                    r_en_d;
    logic [ADDRESS_SIZE-1:0] r_addr_d;
    logic [WORD_SIZE-1:0]    sequence_d;
    logic                    step_d;
    logic                    done_d;

    logic [ADDRESS_SIZE-1:0] start_q, start_d;
    logic [ADDRESS_SIZE-1:0] end_q, end_d;
    logic                    loop_q, loop_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;

    logic timer_clear;
    logic timer_expired;

    // Timer is held at zero outside HOLD, so each word starts counting from 0
    assign timer_clear = (state_q != HOLD);

    step_timer #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_step_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .period (period_q),
        .expired(timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        r_en_d     = r_en;
        r_addr_d   = r_addr;
        sequence_d = sequence_word;
        step_d     = 1'b0;
        done_d     = 1'b0;
        start_d    = start_q;
        end_d      = end_q;
        loop_d     = loop_q;
        period_d   = period_q;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    start_d  = start_addr;
                    end_d    = end_addr;
                    loop_d   = loop;
                    period_d = (step_period == '0) ? PERIOD_WIDTH'(1) : step_period;
                    r_addr_d = start_addr;
                    r_en_d   = 1'b1;
                    state_d  = FETCH;
                end
            end

            FETCH: begin
                if (stop) begin
                    r_en_d  = 1'b0;
                    state_d = IDLE;
                end else if (r_ready) begin
                    sequence_d = r_data;
                    step_d     = 1'b1;
                    r_en_d     = 1'b0;
                    state_d    = HOLD;
                end
            end

            HOLD: begin
                if (stop) begin
                    r_en_d  = 1'b0;
                    state_d = IDLE;
                end else if (timer_expired) begin
                    if (r_addr != end_q) begin
                        r_addr_d = r_addr + ADDRESS_SIZE'(1);
                        r_en_d   = 1'b1;
                        state_d  = FETCH;
                    end else if (loop_q) begin
                        r_addr_d = start_q;
                        r_en_d   = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                r_en_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            r_en          <= 1'b0;
            r_addr        <= '0;
            sequence_word <= '0;
            step          <= 1'b0;
            done          <= 1'b0;
            start_q       <= '0;
            end_q         <= '0;
            loop_q        <= 1'b0;
            period_q      <= PERIOD_WIDTH'(1);
        end else begin
            state_q       <= state_d;
            r_en          <= r_en_d;
            r_addr        <= r_addr_d;
            sequence_word <= sequence_d;
            step          <= step_d;
            done          <= done_d;
            start_q       <= start_d;
            end_q         <= end_d;
            loop_q        <= loop_d;
            period_q      <= period_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_pattern_controller.sv
// Directed self-checking bench for pattern_controller with a 16-word memory model.
module tb_pattern_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        loop;
    logic [3:0]  start_addr;
    logic [3:0]  end_addr;
    logic [15:0] step_period;
    logic        r_ready;
    logic [7:0]  r_data;
    logic        r_en;
    logic [3:0]  r_addr;
    logic [7:0]  sequence_word;
    logic        busy;
    logic        step;
    logic        done;

    logic [7:0] mem [16];

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    always #5 clock = ~clock;

    assign r_data = mem[r_addr];

    pattern_controller #(
        .WORD_SIZE   (8),
        .ADDRESS_SIZE(4),
        .PERIOD_WIDTH(16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .loop         (loop),
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .step_period  (step_period),
        .r_ready      (r_ready),
        .r_data       (r_data),
        .r_en         (r_en),
        .r_addr       (r_addr),
        .sequence_word(sequence_word),
        .busy         (busy),
        .step         (step),
        .done         (done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
        cycle++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        start_addr = '0; end_addr = '0; step_period = 16'd1; r_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({r_en, r_addr, sequence_word, busy, step, done} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0000",
                     {r_en, r_addr, sequence_word, busy, step, done});
        end
        start = 1'b1; stop = 1'b1; start_addr = 4'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({busy, r_en} !== 2'b00) begin
                errors++;
                $display("FAIL start_with_stop: busy/r_en got %b expected 00", {busy, r_en});
            end
        end
        start = 1'b0; stop = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int steps = 0, dones = 0, last_step = 0, done_cyc = 0;
        logic [7:0] expw;
        start_addr = 4'd2; end_addr = 4'd5; step_period = 16'd3; loop = 1'b0; r_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (step) begin
                expw = 8'h12 + 8'(steps);
                checks++;
                if (sequence_word !== expw) begin
                    errors++;
                    $display("FAIL basic_word%0d: got %h expected %h", steps, sequence_word, expw);
                end
                if (steps > 0) begin
                    checks++;
                    if (cycle - last_step != 4) begin
                        errors++;
                        $display("FAIL basic_interval: got %0d expected 4", cycle - last_step);
                    end
                end
                last_step = cycle;
                steps++;
            end
            if (done) begin
                dones++;
                done_cyc = cycle;
            end
        end
        checks++;
        if (steps != 4) begin errors++; $display("FAIL basic_steps: got %0d expected 4", steps); end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", dones); end
        checks++;
        if (done_cyc - last_step != 3) begin
            errors++;
            $display("FAIL basic_done_delay: got %0d expected 3", done_cyc - last_step);
        end
        checks++;
        if ({busy, r_en, r_addr} !== 6'b00_0101) begin
            errors++;
            $display("FAIL basic_final: busy/r_en/r_addr got %b expected 000101", {busy, r_en, r_addr});
        end
    endtask

    task automatic test_wrap_loop();
        logic [7:0] exp_w [6];
        int steps = 0, last_step = 0, dones = 0;
        exp_w[0] = 8'h1E; exp_w[1] = 8'h1F; exp_w[2] = 8'h10;
        exp_w[3] = 8'h11; exp_w[4] = 8'h1E; exp_w[5] = 8'h1F;
        start_addr = 4'd14; end_addr = 4'd1; step_period = 16'd1; loop = 1'b1; r_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0; loop = 1'b0;
        for (int i = 0; i < 40 && steps < 6; i++) begin
            tick();
            if (done) dones++;
            if (step) begin
                checks++;
                if (sequence_word !== exp_w[steps]) begin
                    errors++;
                    $display("FAIL wrap_word%0d: got %h expected %h", steps, sequence_word, exp_w[steps]);
                end
                if (steps > 0) begin
                    checks++;
                    if (cycle - last_step != 2) begin
                        errors++;
                        $display("FAIL wrap_interval: got %0d expected 2", cycle - last_step);
                    end
                end
                last_step = cycle;
                steps++;
            end
        end
        checks++;
        if (steps != 6) begin errors++; $display("FAIL wrap_steps: got %0d expected 6", steps); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if ({busy, r_en, done} !== 3'b000 || dones != 0) begin
            errors++;
            $display("FAIL stop_state: busy/r_en/done got %b (done seen %0d) expected 000",
                     {busy, r_en, done}, dones);
        end
        checks++;
        if ({sequence_word, r_addr} !== {8'h1F, 4'd15}) begin
            errors++;
            $display("FAIL stop_hold: seq/addr got %h/%h expected 1f/f", sequence_word, r_addr);
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL stop_after: busy/done got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_stall();
        int steps = 0, dones = 0;
        start_addr = 4'd3; end_addr = 4'd4; step_period = 16'd2; loop = 1'b0; r_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({r_en, r_addr, step, sequence_word} !== {1'b1, 4'd3, 1'b0, 8'h1F}) begin
                errors++;
                $display("FAIL stall_wait%0d: r_en/addr/step/seq got %b/%h/%b/%h expected 1/3/0/1f",
                         i, r_en, r_addr, step, sequence_word);
            end
            tick();
        end
        r_ready = 1'b1;
        tick();
        checks++;
        if ({step, sequence_word, r_en} !== {1'b1, 8'h13, 1'b0}) begin
            errors++;
            $display("FAIL stall_release: step/seq/r_en got %b/%h/%b expected 1/13/0",
                     step, sequence_word, r_en);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step) steps++;
            if (done) dones++;
        end
        checks++;
        if (steps != 1 || dones != 1 || sequence_word !== 8'h14) begin
            errors++;
            $display("FAIL stall_finish: steps/dones/seq got %0d/%0d/%h expected 1/1/14",
                     steps, dones, sequence_word);
        end
    endtask

    task automatic test_period0_single();
        start_addr = 4'd7; end_addr = 4'd7; step_period = 16'd0; loop = 1'b0; r_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0; start_addr = 4'd0;
        tick();
        checks++;
        if ({step, sequence_word, busy} !== {1'b1, 8'h17, 1'b1}) begin
            errors++;
            $display("FAIL single_word: step/seq/busy got %b/%h/%b expected 1/17/1", step, sequence_word, busy);
        end
        tick();
        checks++;
        if ({done, busy, step, r_addr} !== {1'b1, 1'b0, 1'b0, 4'd7}) begin
            errors++;
            $display("FAIL single_done: done/busy/step/addr got %b/%b/%b/%h expected 1/0/0/7",
                     done, busy, step, r_addr);
        end
        tick();
        checks++;
        if ({done, busy, r_en, sequence_word} !== {3'b000, 8'h17}) begin
            errors++;
            $display("FAIL single_after: done/busy/r_en/seq got %b/%b/%b/%h expected 0/0/0/17",
                     done, busy, r_en, sequence_word);
        end
    endtask

    task automatic test_reset_mid();
        start_addr = 4'd0; end_addr = 4'd3; step_period = 16'd4; loop = 1'b0; r_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, sequence_word} !== {1'b1, 8'h10}) begin
            errors++;
            $display("FAIL mid_pre: busy/seq got %b/%h expected 1/10", busy, sequence_word);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({r_en, r_addr, sequence_word, busy, step, done} !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset: got %h expected 0000", {r_en, r_addr, sequence_word, busy, step, done});
        end
        start_addr = 4'd8; end_addr = 4'd9; step_period = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({r_en, r_addr} !== {1'b1, 4'd8}) begin
            errors++;
            $display("FAIL restart_fetch: r_en/addr got %b/%h expected 1/8", r_en, r_addr);
        end
        tick();
        checks++;
        if ({step, sequence_word} !== {1'b1, 8'h18}) begin
            errors++;
            $display("FAIL restart_word0: step/seq got %b/%h expected 1/18", step, sequence_word);
        end
        tick();
        tick();
        checks++;
        if ({step, sequence_word} !== {1'b1, 8'h19}) begin
            errors++;
            $display("FAIL restart_word1: step/seq got %b/%h expected 1/19", step, sequence_word);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL restart_done: done/busy got %b expected 10", {done, busy});
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        test_reset();
        test_basic();
        test_wrap_loop();
        test_stall();
        test_period0_single();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
